load_store_unit: RTL and testbench

- Initiator side of the core's data-memory interface; sits between the execute stage and the data memory.
- Accepts one load/store per request and converts byte address + size into word-aligned memory beats with byte enables.
- Splits misaligned accesses into two beats, then merges and sign/zero-extends load data.
- Stalls the core until the access completes.

---
 rtl/load_store_unit.sv | 188 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of the core's data-memory interface. Takes one load/store
//   at a time from the execute stage and turns the byte address and size into
//   word-aligned memory beats with byte enables. An access that crosses a word
//   boundary is split into two beats, and the two read words are merged. Load
//   data is then sign- or zero-extended. The core is stalled until the access
//   completes.
//
// Parameters
//   ALLOW_MISALIGNED : 1 = split word-crossing accesses into two beats,
//                      0 = report core_err and issue no memory access
//
// Ports
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   core_req          request, held with its operands until core_stall is low
//   core_we           1 = store, 0 = load
//   core_size         0 byte, 1 half, 2 word, 4 ubyte, 5 uhalf (others invalid)
//   core_addr         byte address
//   core_wdata        store data, LSB-aligned
//   core_stall        high while a request is in progress (combinational)
//   core_rdata        extended load data, valid when core_stall drops
//   core_err          invalid size / disallowed misaligned access
//   mem_req/we/addr/be/wdata   registered memory beat request
//   mem_rdata         read word, sampled when mem_ready is high
//   mem_ready         beat accepted/completed this cycle
module load_store_unit #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [2:0]  core_size,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_stall,
    output logic [31:0] core_rdata,
    output logic        core_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    state_t      state;
    state_t      state_next;

    // Operands captured at request acceptance
    logic [2:0]  size_q;
    logic [1:0]  offset_q;
    logic        we_q;
    logic        mis_q;
    logic [3:0]  be_hi_q;
    logic [31:0] wdata_hi_q;
    logic [31:0] buf0;

    logic        in_valid;
    logic        in_mis;
    logic [7:0]  lanes_be;
    logic [63:0] lanes_wd;

    function automatic logic size_valid(input logic [2:0] size);
        return (size == 3'd0) || (size == 3'd1) || (size == 3'd2) ||
               (size == 3'd4) || (size == 3'd5);
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] size);
        case (size[1:0])
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] offset);
        return ((size[1:0] == 2'd1) && (offset == 2'd3)) ||
               ((size[1:0] == 2'd2) && (offset != 2'd0));
    endfunction

    // Shift the {hi,lo} pair down to the access offset, then extend.
    function automatic logic [31:0] extend_load(input logic [31:0] lo, input logic [31:0] hi,
                                                input logic [1:0] offset, input logic [2:0] size);
        logic [31:0] raw;
        raw = 32'({hi, lo} >> {offset, 3'b000});
        case (size)
            3'd0:    return {{24{raw[7]}}, raw[7:0]};
            3'd1:    return {{16{raw[15]}}, raw[15:0]};
            3'd4:    return {24'd0, raw[7:0]};
            3'd5:    return {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // The low half of each 8-bit / 64-bit lane image is beat 0, the high half beat 1.
    assign in_valid   = size_valid(core_size);
    assign in_mis     = is_misaligned(core_size, core_addr[1:0]);
    assign lanes_be   = {4'b0000, size_mask(core_size)} << core_addr[1:0];
    assign lanes_wd   = {32'd0, core_wdata} << {core_addr[1:0], 3'b000};
    assign core_stall = core_req && (state != DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (core_req) begin
                    if (!in_valid || (in_mis && !ALLOW_MISALIGNED)) state_next = DONE;
                    else                                             state_next = BEAT0;
                end
            end
            BEAT0: if (mem_ready) state_next = mis_q ? BEAT1 : DONE;
            BEAT1: if (mem_ready) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // ---- request capture / read buffer (no reset needed, qualified by state) ----
    always_ff @(posedge clk) begin
        if (state == IDLE && core_req) begin
            size_q     <= core_size;
            offset_q   <= core_addr[1:0];
            we_q       <= core_we;
            mis_q      <= in_mis;
            be_hi_q    <= lanes_be[7:4];
            wdata_hi_q <= lanes_wd[63:32];
        end
        if (state == BEAT0 && mem_ready) buf0 <= mem_rdata;
    end

    // ---- registered memory beat and core response ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_be     <= 4'd0;
            mem_wdata  <= 32'd0;
            core_rdata <= 32'd0;
            core_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_next == BEAT0) begin
                        mem_req   <= 1'b1;
                        mem_we    <= core_we;
                        mem_addr  <= {core_addr[31:2], 2'b00};
                        mem_be    <= lanes_be[3:0];
                        mem_wdata <= lanes_wd[31:0];
                    end else if (state_next == DONE) begin
                        core_err   <= 1'b1;
                        core_rdata <= 32'd0;
                    end
                end
                BEAT0: begin
                    if (mem_ready) begin
                        if (mis_q) begin
                            mem_addr  <= mem_addr + 32'd4;
                            mem_be    <= be_hi_q;
                            mem_wdata <= wdata_hi_q;
                        end else begin
                            mem_req    <= 1'b0;
                            core_err   <= 1'b0;
                            core_rdata <= we_q ? 32'd0 : extend_load(mem_rdata, 32'd0, offset_q, size_q);
                        end
                    end
                end
                BEAT1: begin
                    if (mem_ready) begin
                        mem_req    <= 1'b0;
                        core_err   <= 1'b0;
                        core_rdata <= we_q ? 32'd0 : extend_load(buf0, mem_rdata, offset_q, size_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [2:0]  core_size = 3'd0;
    logic [31:0] core_addr = 32'd0;
    logic [31:0] core_wdata = 32'd0;
    logic        core_stall;
    logic [31:0] core_rdata;
    logic        core_err;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    // second instance with misaligned accesses disallowed
    logic        core_req2 = 1'b0;
    logic        core_stall2, core_err2, mem_req2, mem_we2;
    logic [31:0] core_rdata2, mem_addr2, mem_wdata2;
    logic [3:0]  mem_be2;

    // memory model
    logic [31:0] rd0_v = 32'd0, rd1_v = 32'd0;
    int          wait1 = 0;
    logic        force_ready = 1'b0;
    int          beat_idx = 0, wcnt = 0, log_n = 0, req2_cnt = 0;
    logic [31:0] log_addr [256];
    logic [31:0] log_wd   [256];
    logic [3:0]  log_be   [256];
    logic        log_we   [256];

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    assign mem_ready = force_ready | (mem_req && (beat_idx == 0 || wcnt >= wait1));
    assign mem_rdata = (beat_idx == 0) ? rd0_v : rd1_v;

    load_store_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .core_req(core_req), .core_we(core_we),
        .core_size(core_size), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_stall(core_stall), .core_rdata(core_rdata), .core_err(core_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready));

    load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .core_req(core_req2), .core_we(core_we),
        .core_size(core_size), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_stall(core_stall2), .core_rdata(core_rdata2), .core_err(core_err2),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_be(mem_be2),
        .mem_wdata(mem_wdata2), .mem_rdata(32'h0BAD_F00D), .mem_ready(mem_req2));

    always @(posedge clk) begin
        if (!mem_req) begin
            beat_idx <= 0;
            wcnt     <= 0;
        end else if (mem_ready) begin
            beat_idx <= beat_idx + 1;
            wcnt     <= 0;
            log_addr[log_n % 256] <= mem_addr;
            log_wd[log_n % 256]   <= mem_wdata;
            log_be[log_n % 256]   <= mem_be;
            log_we[log_n % 256]   <= mem_we;
            log_n <= log_n + 1;
        end else begin
            wcnt <= wcnt + 1;
        end
        if (mem_req2) req2_cnt <= req2_cnt + 1;
    end

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr, wdata, rd0, rd1;
        int          w1;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_stall, exp_beats;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0, a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int stall;
        int base;
        string nm;
        nm = $sformatf("v%0d", idx);
        @(negedge clk);
        rd0_v = v.rd0; rd1_v = v.rd1; wait1 = v.w1;
        core_we = v.we; core_size = v.size; core_addr = v.addr; core_wdata = v.wdata;
        base = log_n;
        core_req = 1'b1;
        #1;
        stall = 0;
        for (int k = 0; k < 64 && core_stall; k++) begin
            stall++;
            @(negedge clk);
        end
        chk({nm, "_stall"}, 32'(stall), 32'(v.exp_stall));
        chk({nm, "_rdata"}, core_rdata, v.exp_rdata);
        chk({nm, "_err"}, 32'(core_err), 32'(v.exp_err));
        chk({nm, "_beats"}, 32'(log_n - base), 32'(v.exp_beats));
        if (v.exp_beats >= 1) begin
            chk({nm, "_addr0"}, log_addr[base % 256], v.a0);
            chk({nm, "_be0"}, 32'(log_be[base % 256]), 32'(v.be0));
            chk({nm, "_we0"}, 32'(log_we[base % 256]), 32'(v.we));
            if (v.we) chk({nm, "_wd0"}, log_wd[base % 256], v.wd0);
        end
        if (v.exp_beats == 2) begin
            chk({nm, "_addr1"}, log_addr[(base + 1) % 256], v.a1);
            chk({nm, "_be1"}, 32'(log_be[(base + 1) % 256]), 32'(v.be1));
            if (v.we) chk({nm, "_wd1"}, log_wd[(base + 1) % 256], v.wd1);
        end
        core_req = 1'b0;
    endtask

    initial begin
        int stall;
        logic [31:0] held;
        vecs[0]  = '{1'b0, 3'd2, 32'h100, 32'h0, 32'h8765_4321, 32'h0, 0, 32'h8765_4321, 1'b0, 2, 1,
                     32'h100, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[1]  = '{1'b0, 3'd0, 32'h103, 32'h0, 32'h8012_3456, 32'h0, 0, 32'hFFFF_FF80, 1'b0, 2, 1,
                     32'h100, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[2]  = '{1'b0, 3'd4, 32'h103, 32'h0, 32'h8012_3456, 32'h0, 0, 32'h0000_0080, 1'b0, 2, 1,
                     32'h100, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[3]  = '{1'b1, 3'd1, 32'h102, 32'h0000_BEEF, 32'h0, 32'h0, 0, 32'h0, 1'b0, 2, 1,
                     32'h100, 4'hC, 32'hBEEF_0000, 32'h0, 4'h0, 32'h0};
        vecs[4]  = '{1'b0, 3'd2, 32'h101, 32'h0, 32'hDDCC_BBAA, 32'h4433_2211, 0, 32'h11DD_CCBB, 1'b0, 3, 2,
                     32'h100, 4'hE, 32'h0, 32'h104, 4'h1, 32'h0};
        vecs[5]  = '{1'b0, 3'd2, 32'h101, 32'h0, 32'hDDCC_BBAA, 32'h4433_2211, 3, 32'h11DD_CCBB, 1'b0, 6, 2,
                     32'h100, 4'hE, 32'h0, 32'h104, 4'h1, 32'h0};
        vecs[6]  = '{1'b0, 3'd1, 32'h103, 32'h0, 32'h7F00_0000, 32'h0000_00FF, 0, 32'hFFFF_FF7F, 1'b0, 3, 2,
                     32'h100, 4'h8, 32'h0, 32'h104, 4'h1, 32'h0};
        vecs[7]  = '{1'b0, 3'd5, 32'h102, 32'h0, 32'h9ABC_0000, 32'h0, 0, 32'h0000_9ABC, 1'b0, 2, 1,
                     32'h100, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[8]  = '{1'b1, 3'd2, 32'h103, 32'hA1B2_C3D4, 32'h0, 32'h0, 0, 32'h0, 1'b0, 3, 2,
                     32'h100, 4'h8, 32'hD400_0000, 32'h104, 4'h7, 32'h00A1_B2C3};
        vecs[9]  = '{1'b0, 3'd3, 32'h100, 32'h0, 32'h1234_5678, 32'h0, 0, 32'h0, 1'b1, 1, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[10] = '{1'b1, 3'd7, 32'h200, 32'h0000_1234, 32'h0, 32'h0, 0, 32'h0, 1'b1, 1, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[11] = '{1'b0, 3'd2, 32'hFFFF_FFFD, 32'h0, 32'h1122_3344, 32'h5566_7788, 0, 32'h8811_2233, 1'b0, 3, 2,
                     32'hFFFF_FFFC, 4'hE, 32'h0, 32'h0, 4'h1, 32'h0};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", core_rdata, 32'd0);
        chk("rst_err", 32'(core_err), 32'd0);
        chk("rst_stall", 32'(core_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // mem_ready while idle must not start or disturb anything
        held = core_rdata;
        @(negedge clk);
        force_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_ready_req", 32'(mem_req), 32'd0);
            chk("idle_ready_rdata", core_rdata, held);
        end
        force_ready = 1'b0;

        // misaligned store rejected when splitting is disabled
        @(negedge clk);
        core_we = 1'b1; core_size = 3'd2; core_addr = 32'h102; core_wdata = 32'h5555_AAAA;
        stall = req2_cnt;
        core_req2 = 1'b1;
        #1 chk("nomis_stall_n", 32'(core_stall2), 32'd1);
        @(negedge clk);
        chk("nomis_stall_n1", 32'(core_stall2), 32'd0);
        chk("nomis_err", 32'(core_err2), 32'd1);
        chk("nomis_rdata", core_rdata2, 32'd0);
        chk("nomis_no_req", 32'(req2_cnt - stall), 32'd0);
        core_req2 = 1'b0;

        // aligned load still works on that instance
        @(negedge clk);
        core_we = 1'b0; core_size = 3'd2; core_addr = 32'h100;
        core_req2 = 1'b1;
        #1;
        stall = 0;
        for (int k = 0; k < 64 && core_stall2; k++) begin
            stall++;
            @(negedge clk);
        end
        chk("nomis_lw_stall", 32'(stall), 32'd2);
        chk("nomis_lw_rdata", core_rdata2, 32'h0BAD_F00D);
        chk("nomis_lw_err", 32'(core_err2), 32'd0);
        core_req2 = 1'b0;

        // reset while the second beat of a misaligned store is stalled
        @(negedge clk);
        wait1 = 5;
        core_we = 1'b1; core_size = 3'd2; core_addr = 32'h103; core_wdata = 32'hCAFE_F00D;
        core_req = 1'b1;
        for (int k = 0; k < 20 && beat_idx != 1; k++) @(negedge clk);
        chk("rstmid_in_beat1", mem_addr, 32'h104);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rstmid_mem_req", 32'(mem_req), 32'd0);
        chk("rstmid_mem_we", 32'(mem_we), 32'd0);
        chk("rstmid_mem_addr", mem_addr, 32'd0);
        chk("rstmid_mem_be", 32'(mem_be), 32'd0);
        chk("rstmid_mem_wdata", mem_wdata, 32'd0);
        chk("rstmid_rdata", core_rdata, 32'd0);
        chk("rstmid_err", 32'(core_err), 32'd0);
        chk("rstmid_stall_idle", 32'(core_stall), 32'd1);
        core_req = 1'b0;
        #1 chk("rstmid_stall_off", 32'(core_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait1 = 0;

        // back in IDLE: a fresh access behaves normally
        run_vec(12, vecs[0]);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
